log_calc_seq: RTL
=================

Name: log_calc_seq

Overview:
- Runtime counterpart to the elaboration-time sizing functions.
- Computes floor(log_b(n)) and ceil(log_b(n)) for an unsigned n and a base b supplied at runtime.
- Works in the exponent direction: repeatedly multiplies a running power by b until the power reaches n.
- Sits behind valid/ready streams, e.g. for computing address or burst widths from runtime configuration registers.

Parameters:
- N_WIDTH, 32, width of operand n.
- B_WIDTH, 8, width of base b.
- LOG_WIDTH (localparam), bit_size(N_WIDTH), width of the log results. Holds values up to N_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  request valid.
- s_ready  out  1  request ready.
- s_n  in  N_WIDTH  operand n.
- s_base  in  B_WIDTH  base b.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_floor_log  out  LOG_WIDTH  floor(log_b(n)).
- m_ceil_log  out  LOG_WIDTH  ceil(log_b(n)).
- m_error  out  1  illegal request: n==0 or b<2.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over all other logic.
- Reset values:
  - state=IDLE, s_ready=1.
  - m_valid=0, m_floor_log=0, m_ceil_log=0, m_error=0.
  - Internal power, k and captured operands = 0.
- States: IDLE, RUN, DONE.
- s_ready = (state==IDLE), registered. m_valid = (state==DONE).
- IDLE:
  - On an edge with s_valid&&s_ready, capture s_n and s_base. Later changes on s_* are ignored.
  - If n==0 or b<2: m_error=1, floor=ceil=0, go to DONE.
  - Otherwise: power=1, k=0, go to RUN.
- RUN, per edge:
  - If power>=n: ceil=k; floor = (power==n) ? k : k-1; m_error=0; go to DONE.
  - Otherwise: power=power*b, k=k+1.
- Width rule:
  - power is N_WIDTH+B_WIDTH bits. Since power<n<2^N_WIDTH before each multiply, the product always fits; no saturation is needed.
  - The multiply is a single-cycle full product.
- Latency (edges from the accepting edge to m_valid high):
  - Legal request: ceil_log+1.
  - Error request: 1.
- DONE:
  - Outputs held stable while m_ready=0 (backpressure of unlimited duration).
  - On an edge with m_ready=1: go to IDLE, m_valid deasserts, s_ready asserts after that same edge.
  - No overlap of result and next request: throughput is at most 1 request per latency+2 cycles.
- Results stay on the m_* outputs after the handshake until overwritten; they are only meaningful while m_valid=1.
- rst asserted mid-RUN or mid-DONE aborts the operation. Any pending result is discarded; outputs return to their reset values after the edge.
- n=1 for any legal b: floor=ceil=0, latency 1.

Optional Feature:
- Macro: LOG_CALC_POWER_EN.
- When defined:
  - Adds output m_power (out, N_WIDTH+B_WIDTH) = b^ceil_log, the smallest power of b >= n.
  - Registered in the same edge as the other results, held while m_valid=1.
  - Reset value 0; value 0 on error results.
- When undefined:
  - Port absent.
  - The power register is still used internally; no other behavioural change.

Test Plan:
- n=1, b=2 -> floor=0, ceil=0, error=0; m_valid 1 edge after accept.
- n=8, b=2 -> floor=3, ceil=3, latency 4. n=9, b=2 -> floor=3, ceil=4, latency 5. With the macro: m_power=8 and 16.
- n=1000, b=10 -> 3/3. n=1001, b=10 -> 3/4. n=255, b=255 -> 1/1. n=256, b=255 -> 1/2.
- n=0, b=5 and n=7, b=1 -> error=1, floor=ceil=0, latency 1. A following legal request (n=4, b=2 -> 2/2) is correct.
- n=2^32-1, b=2 -> floor=31, ceil=32, no overflow (m_power=2^32). Hold m_ready=0 for 10 cycles -> outputs stable and s_ready=0 throughout; s_ready=1 one edge after m_ready=1.
- Assert rst for 1 cycle in the 3rd RUN cycle of n=1000, b=2 -> m_valid=0 and s_ready=1 after reset. A new request n=5, b=3 -> floor=1, ceil=2.

Source files
------------

// File: rtl/log_calc_seq.sv
// log_calc_seq: sequential floor/ceil of log_b(n), found by multiplying a running power by b until it reaches n.
// Defining LOG_CALC_POWER_EN adds the m_power output (b^ceil_log).
module log_calc_seq #(
  parameter  int N_WIDTH   = 32,
  parameter  int B_WIDTH   = 8,
  localparam int LOG_WIDTH = $clog2(N_WIDTH + 1),
  localparam int P_WIDTH   = N_WIDTH + B_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N_WIDTH-1:0]   s_n,
  input  logic [B_WIDTH-1:0]   s_base,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LOG_WIDTH-1:0] m_floor_log,
  output logic [LOG_WIDTH-1:0] m_ceil_log,
  output logic                 m_error
`ifdef LOG_CALC_POWER_EN
  ,
  output logic [P_WIDTH-1:0]   m_power
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [P_WIDTH-1:0]   power;
  logic [LOG_WIDTH-1:0] k;
  logic [N_WIDTH-1:0]   n_q;
  logic [B_WIDTH-1:0]   b_q;
  logic [P_WIDTH-1:0]   n_ext;
  logic [P_WIDTH-1:0]   b_ext;

  // power < n < 2^N_WIDTH before every multiply, so the product never exceeds P_WIDTH bits
  assign n_ext = {{B_WIDTH{1'b0}}, n_q};
  assign b_ext = {{N_WIDTH{1'b0}}, b_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_floor_log <= '0;
      m_ceil_log  <= '0;
      m_error     <= 1'b0;
      power       <= '0;
      k           <= '0;
      n_q         <= '0;
      b_q         <= '0;
`ifdef LOG_CALC_POWER_EN
      m_power     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            n_q     <= s_n;
            b_q     <= s_base;
            s_ready <= 1'b0;
            if ((s_n == '0) || (s_base < B_WIDTH'(2))) begin
              m_error     <= 1'b1;
              m_floor_log <= '0;
              m_ceil_log  <= '0;
              m_valid     <= 1'b1;
              state       <= DONE;
`ifdef LOG_CALC_POWER_EN
              m_power     <= '0;
`endif
            end else begin
              power <= P_WIDTH'(1);
              k     <= '0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (power >= n_ext) begin
            m_ceil_log  <= k;
            m_floor_log <= (power == n_ext) ? k : (k - LOG_WIDTH'(1));
            m_error     <= 1'b0;
            m_valid     <= 1'b1;
            state       <= DONE;
`ifdef LOG_CALC_POWER_EN
            m_power     <= power;
`endif
          end else begin
            power <= power * b_ext;
            k     <= k + LOG_WIDTH'(1);
          end
        end

        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
